// File: rtl/mult_datapath.sv
// Datapath for the 8-bit signed add-shift multiplier: A, B and X registers.
// Ports: Clk, Reset, S, Clr_Ld, ClearA, Add, Sub, Shift -> Aval, Bval, X, Bin.
module mult_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] S,
  input  logic             Clr_Ld,
  input  logic             ClearA,
  input  logic             Add,
  input  logic             Sub,
  input  logic             Shift,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             X,
  output logic [WIDTH-1:0] Bin
);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             x_q;

  logic [WIDTH:0] a_ext;
  logic [WIDTH:0] s_ext;
  logic [WIDTH:0] sum;

  // Sign-extend to 9 bits so the top bit of the result is the true sign.
  assign a_ext = {a_q[WIDTH-1], a_q};
  assign s_ext = {S[WIDTH-1], S};

  // Sub has priority over Add when both are asserted.
  assign sum = Sub ? (a_ext - s_ext) : (a_ext + s_ext);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      a_q <= '0;
      b_q <= '0;
      x_q <= 1'b0;
    end else if (Clr_Ld || ClearA) begin
      if (ClearA) a_q <= '0;
      if (Clr_Ld) b_q <= S;
      x_q <= 1'b0;
    end else if (Add || Sub) begin
      {x_q, a_q} <= sum;
    end else if (Shift) begin
      a_q <= {x_q, a_q[WIDTH-1:1]};
      b_q <= {a_q[0], b_q[WIDTH-1:1]};
    end
  end

  assign Aval = a_q;
  assign Bval = b_q;
  assign X    = x_q;
  assign Bin  = b_q;

endmodule

// File: doc/mult_datapath.md
# mult_datapath

Register and arithmetic datapath for the 8-bit signed add-shift multiplier. It holds the partial-product register A, the multiplier register B and the sign-extension bit X, and executes one micro-operation per clock as commanded by the multiplier control unit (Clr_Ld, ClearA, Add, Sub, Shift). It returns B[0] to the control unit as Bin and presents {X, A, B} to the display/hex-driver stage. The multiplicand is taken directly from the switch bus S on every Add/Sub.

## Interface
- WIDTH, 8, operand width; A, B and S are WIDTH bits, the adder is WIDTH+1 bits.

- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high; sampled on the rising edge of Clk.
- S  in  WIDTH  switch bus; multiplicand for Add/Sub, load value for B on Clr_Ld.
- Clr_Ld  in  1  load B <= S and clear X (one cycle).
- ClearA  in  1  clear A and X (one cycle).
- Add  in  1  A <= A + S (signed), X <= sign of 9-bit result.
- Sub  in  1  A <= A - S (signed), X <= sign of 9-bit result.
- Shift  in  1  arithmetic right shift of the {X, A, B} chain.
- Aval  out  WIDTH  current A register.
- Bval  out  WIDTH  current B register.
- X  out  1  current sign-extension bit.
- Bin  out  WIDTH  full B register to control unit; control uses Bin[0].

## Operation
- State: A[WIDTH-1:0], B[WIDTH-1:0], X; no other registers.
- Per-edge priority, highest first: Reset; load/clear group; Add/Sub; Shift; hold.
- Reset: A=0, B=0, X=0 (so Aval=0, Bval=0, X=0, Bin=0).
- Load/clear group (either asserted): ClearA -> A=0, X=0; Clr_Ld -> B=S, X=0. Both asserted -> all three actions in the same edge. When this group fires, Add/Sub/Shift are ignored that cycle.
- Add: 9-bit sum = {A[7],A} + {S[7],S}; A <= sum[7:0], X <= sum[8]. B unchanged.
- Sub: 9-bit diff = {A[7],A} + ~{S[7],S} + 1; A <= diff[7:0], X <= diff[8]. B unchanged.
- Add and Sub together: Sub wins (Add ignored). Add/Sub together with Shift: arithmetic op wins, Shift ignored that cycle.
- Shift: X <= X; A <= {X, A[7:1]}; B <= {A[0], B[7:1]}. Discarded bit is old B[0].
- No control asserted: all registers hold.
- Arithmetic is modulo 2^9 on the extended word; no overflow flag. With 8-bit signed operands the 9-bit result never overflows, so X is always the true sign.
- After a complete control sequence (clear, 7x [optional Add, Shift], final [optional Sub, Shift]), {A, B} is the 16-bit two's-complement product of S and the value loaded into B; X equals product sign.

## Timing
- All outputs are direct register outputs; no combinational path from any input to any output.
- Latency: each micro-op visible on outputs one cycle after the edge that samples it.
- Bin[0] after an edge reflects the post-update B, valid for control's next-state decision in the following cycle.
- S must be stable in any cycle where Add, Sub or Clr_Ld is high; S is not registered.
- Reset mid-multiply: next edge forces A=B=X=0 regardless of any other input; no partial op completes.
- Controls held high for multiple cycles repeat the operation every cycle (e.g., Shift held 3 cycles = 3 shifts).

## Test plan
- Reset with S=0xA5, Add=1, Shift=1 -> next cycle Aval=0x00, Bval=0x00, X=0.
- Clr_Ld=1 with S=0xFD, then ClearA=1 -> Bval=0xFD, Aval=0x00, X=0, Bin[0]=1.
- Load B=0xFD (-3), S=0x07; drive the full add/shift sequence per B bits, final Sub on bit 7 -> {Aval,Bval}=0xFFEB (-21), X=1.
- Load B=0x80, S=0x80; full sequence (only final Sub, then Shift) -> {Aval,Bval}=0x4000, X=0; check intermediate after Sub: Aval=0x80, X=0.
- A=0x7F (via Add with S=0x7F from 0), Add again with S=0x7F -> Aval=0xFE, X=0; Shift -> Aval=0x7F, Bval MSB=0.
- Add=1, Sub=1, Shift=1 together with A=0x05, S=0x03 -> Aval=0x02, X=0, Bval unchanged; then Reset mid-sequence after 3 shifts -> all zero next cycle.
